gpio_pinmux_ctrl: RTL and testbench
===================================

Name: gpio_pinmux_ctrl

Overview:
- Configuration sequencer for the per-pin bidirectional I/O mux: drives its per-pin port-select, output-enable and open-drain inputs.
- Host writes per-pin settings into a shadow register file. A commit request applies them in a glitch-safe sequence: disable changed drivers, wait a guard time, switch the mux, then re-enable.
- Sits between the host register bus and the bidir I/O block. It is the only writer of that block's configuration inputs.

Parameters:
- IOWidth, 36, number of pins / mux inputs.
- PortNumWidth, 8, width of one port-select field.
- AddrWidth, 6, cfg_addr width; must satisfy 2**AddrWidth >= IOWidth.
- GuardCycles, 4, tri-state dwell cycles between driver disable and mux switch; 0 is legal.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_wr  in  1  shadow write strobe, one entry per cycle.
- cfg_rd  in  1  shadow read strobe.
- cfg_addr  in  AddrWidth  pin index.
- cfg_wdata  in  PortNumWidth+2  {od, oe, sel[PortNumWidth-1:0]}.
- cfg_rdata  out  PortNumWidth+2  read data, same layout.
- commit  in  1  apply-shadow request, level-sampled each cycle.
- busy  out  1  commit sequence in progress.
- done  out  1  one-cycle pulse at end of a commit.
- cfg_err  out  1  sticky: dropped write; cleared by reset only.
- portselnum  out  [PortNumWidth-1:0] x IOWidth  live select per pin.
- out_ena  out  IOWidth  live output enables.
- od  out  IOWidth  live open-drain flags.

Behaviour:
- Reset (async assert, sync release):
  - portselnum[i]=i, out_ena=0, od=0.
  - Shadow sel[i]=i, oe=0, od=0.
  - busy=0, done=0, cfg_err=0, cfg_rdata=0, pending=0, state IDLE.
  - Reset mid-sequence aborts the commit; outputs take reset values.
- Writes:
  - cfg_wr with cfg_addr<IOWidth and sel<IOWidth updates the shadow at the clock edge.
  - cfg_addr>=IOWidth, or sel>=IOWidth: write dropped, cfg_err set.
  - Writes are accepted in every state and never touch live outputs directly.
- Reads: cfg_rdata registered, valid 1 cycle after cfg_rd. Out-of-range address returns 0. Value holds until the next read.
- States: IDLE, DISABLE, GUARD, APPLY, ENABLE.
- IDLE: at edge E0 with commit=1 (or pending=1), the shadow is snapshotted. A same-cycle cfg_wr is included via forwarding. Compute changed[i] = snapshot sel/od differs from live sel/od. busy=1; go to DISABLE.
- DISABLE (edge E1): out_ena <= out_ena & ~changed. Go to GUARD if GuardCycles>0, else APPLY.
- GUARD: count GuardCycles cycles, then go to APPLY.
- APPLY (edge E2+G): portselnum and od <= snapshot. Go to ENABLE.
- ENABLE (edge E3+G): out_ena <= snapshot oe; done=1 for one cycle; busy=0; go to IDLE.
- Latency: commit to done = 3+GuardCycles edges. Unchanged pins keep driving throughout; their oe changes only at ENABLE.
- A commit during a non-IDLE state sets pending; multiple requests collapse into one. On return to IDLE, a pending commit starts the next cycle and clears pending.
- Writes during busy affect only the next commit.
- changed==0: the sequence still runs in full; out_ena only changes at ENABLE.

Optional Feature:
- Macro: GPIO_PINMUX_LIVE_READBACK_EN.
- Defined:
  - Adds input cfg_rd_live (1 bit).
  - When high with cfg_rd, cfg_rdata returns {od, out_ena, portselnum} of the live outputs rather than the shadow. Same 1-cycle latency.
- Undefined: port absent; reads return shadow only.

Decomposition:
- gpio_pinmux_pkg holds:
  - state enum.
  - cfg_wdata field offsets: SEL_LSB=0, OE_BIT=PortNumWidth, OD_BIT=PortNumWidth+1.
  - a packed pin-config struct typedef.
- One sub-module, gpio_pinmux_shadow: shadow register file with write validation, forwarding snapshot port and registered read.
- The FSM, changed-mask and live registers stay in gpio_pinmux_ctrl.

Test Plan:
- Reset release -> portselnum[5]=5, out_ena=0, od=0, busy=0; read addr 5 gives cfg_rdata={0,0,5}.
- Write pin 3 {od=0, oe=1, sel=7}, GuardCycles=4, commit -> busy for 7 cycles; out_ena[3] low through APPLY; portselnum[3]=7 at E6; out_ena[3]=1 and done pulse at E7.
- Pin 2 live oe=1 unchanged, while pin 3 changes -> out_ena[2] stays 1 every cycle of the sequence.
- Commit held high during busy, plus a write to pin 4 -> exactly one extra sequence starts the cycle after done and applies pin 4.
- Write cfg_addr=40 or sel=36 -> shadow unchanged, cfg_err=1 and remains set after a subsequent commit.
- Reset asserted during GUARD -> outputs back to identity/zero immediately; no done pulse.

Source files
------------

// File: rtl/gpio_pinmux_pkg.sv
// Shared types for the GPIO pin-mux configuration sequencer: FSM states, cfg word layout,
// per-pin config record and its reset value.
package gpio_pinmux_pkg;

    localparam int unsigned PinSelWidth = 8;

    localparam int unsigned SEL_LSB = 0;
    localparam int unsigned OE_BIT  = PinSelWidth;
    localparam int unsigned OD_BIT  = PinSelWidth + 1;

    typedef enum logic [2:0] {
        StIdle,
        StDisable,
        StGuard,
        StApply,
        StEnable
    } pinmux_state_e;

    typedef struct packed {
        logic                   od;
        logic                   oe;
        logic [PinSelWidth-1:0] sel;
    } pin_cfg_t;

    // Identity routing with the driver off: pin i selects mux input i.
    function automatic pin_cfg_t pin_reset(input int unsigned idx);
        pin_cfg_t cfg;
        cfg.od  = 1'b0;
        cfg.oe  = 1'b0;
        cfg.sel = PinSelWidth'(idx);
        return cfg;
    endfunction

endpackage

// File: rtl/gpio_pinmux_shadow.sv
// Shadow register file: validated writes, forwarded snapshot and registered read port.
// With GPIO_PINMUX_LIVE_READBACK_EN defined, reads can return the live pin config instead.
module gpio_pinmux_shadow
    import gpio_pinmux_pkg::*;
#(
    parameter int unsigned IOWidth   = 36,
    parameter int unsigned AddrWidth = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_i,
    input  logic                   rd_i,
`ifdef GPIO_PINMUX_LIVE_READBACK_EN
    input  logic                   rd_live_i,
    input  pin_cfg_t [IOWidth-1:0] live_i,
`endif
    input  logic [AddrWidth-1:0]   addr_i,
    input  pin_cfg_t               wdata_i,
    output pin_cfg_t [IOWidth-1:0] snap_o,
    output pin_cfg_t               rdata_o,
    output logic                   err_o
);

    pin_cfg_t [IOWidth-1:0] shadow_q, shadow_d;
    pin_cfg_t               rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   addr_ok, sel_ok;

    assign addr_ok = 32'(addr_i) < IOWidth;
    assign sel_ok  = 32'(wdata_i.sel) < IOWidth;

    always_comb begin
        shadow_d = shadow_q;
        err_d    = err_q;
        if (wr_i) begin
            if (addr_ok && sel_ok) begin
                shadow_d[addr_i] = wdata_i;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_i) begin
            if (!addr_ok) begin
                rdata_d = '0;
`ifdef GPIO_PINMUX_LIVE_READBACK_EN
            end else if (rd_live_i) begin
                rdata_d = live_i[addr_i];
`endif
            end else begin
                rdata_d = shadow_q[addr_i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IOWidth; i++) begin
                shadow_q[i] <= pin_reset(i);
            end
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state view lets a commit in the same cycle as a write pick that write up.
    assign snap_o  = shadow_d;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: rtl/gpio_pinmux_ctrl.sv
// Glitch-safe pin-mux configuration sequencer: disable changed drivers, dwell, switch, re-enable.
// Optional GPIO_PINMUX_LIVE_READBACK_EN adds cfg_rd_live_i to read back live pin config.
module gpio_pinmux_ctrl
    import gpio_pinmux_pkg::*;
#(
    parameter int unsigned IOWidth      = 36,
    parameter int unsigned PortNumWidth = PinSelWidth,
    parameter int unsigned AddrWidth    = 6,
    parameter int unsigned GuardCycles  = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 cfg_wr_i,
    input  logic                                 cfg_rd_i,
`ifdef GPIO_PINMUX_LIVE_READBACK_EN
    input  logic                                 cfg_rd_live_i,
`endif
    input  logic [AddrWidth-1:0]                 cfg_addr_i,
    input  logic [PortNumWidth+1:0]              cfg_wdata_i,
    output logic [PortNumWidth+1:0]              cfg_rdata_o,
    input  logic                                 commit_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 cfg_err_o,
    output logic [IOWidth-1:0][PortNumWidth-1:0] portselnum_o,
    output logic [IOWidth-1:0]                   out_ena_o,
    output logic [IOWidth-1:0]                   od_o
);

    localparam int unsigned CntWidth = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;
    localparam logic [CntWidth-1:0] GuardLast =
        (GuardCycles > 0) ? CntWidth'(GuardCycles - 1) : '0;

    pinmux_state_e          state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic                   done_q, done_d;
    logic [IOWidth-1:0]     changed_q, changed_d;
    pin_cfg_t [IOWidth-1:0] snap_q, snap_d;
    pin_cfg_t [IOWidth-1:0] live_q, live_d;
    pin_cfg_t [IOWidth-1:0] snap_fwd;
    pin_cfg_t               wdata;
    pin_cfg_t               rdata;

    assign wdata.od  = cfg_wdata_i[OD_BIT];
    assign wdata.oe  = cfg_wdata_i[OE_BIT];
    assign wdata.sel = cfg_wdata_i[SEL_LSB +: PortNumWidth];

    gpio_pinmux_shadow #(
        .IOWidth   (IOWidth),
        .AddrWidth (AddrWidth)
    ) u_shadow (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_i      (cfg_wr_i),
        .rd_i      (cfg_rd_i),
`ifdef GPIO_PINMUX_LIVE_READBACK_EN
        .rd_live_i (cfg_rd_live_i),
        .live_i    (live_q),
`endif
        .addr_i    (cfg_addr_i),
        .wdata_i   (wdata),
        .snap_o    (snap_fwd),
        .rdata_o   (rdata),
        .err_o     (cfg_err_o)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        changed_d = changed_q;
        snap_d    = snap_q;
        live_d    = live_q;
        unique case (state_q)
            StIdle: begin
                if (commit_i || pending_q) begin
                    pending_d = 1'b0;
                    snap_d    = snap_fwd;
                    for (int i = 0; i < IOWidth; i++) begin
                        changed_d[i] = (snap_fwd[i].sel != live_q[i].sel) ||
                                       (snap_fwd[i].od != live_q[i].od);
                    end
                    state_d = StDisable;
                end
            end
            StDisable: begin
                for (int i = 0; i < IOWidth; i++) begin
                    if (changed_q[i]) live_d[i].oe = 1'b0;
                end
                cnt_d   = '0;
                state_d = (GuardCycles > 0) ? StGuard : StApply;
            end
            StGuard: begin
                if (cnt_q == GuardLast) begin
                    state_d = StApply;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StApply: begin
                for (int i = 0; i < IOWidth; i++) begin
                    live_d[i].sel = snap_q[i].sel;
                    live_d[i].od  = snap_q[i].od;
                end
                state_d = StEnable;
            end
            StEnable: begin
                for (int i = 0; i < IOWidth; i++) begin
                    live_d[i].oe = snap_q[i].oe;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Requests arriving mid-sequence collapse into a single follow-up commit.
        if (state_q != StIdle && commit_i) pending_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            changed_q <= '0;
            for (int i = 0; i < IOWidth; i++) begin
                snap_q[i] <= pin_reset(i);
                live_q[i] <= pin_reset(i);
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            changed_q <= changed_d;
            snap_q    <= snap_d;
            live_q    <= live_d;
        end
    end

    always_comb begin
        for (int i = 0; i < IOWidth; i++) begin
            portselnum_o[i] = live_q[i].sel;
            out_ena_o[i]    = live_q[i].oe;
            od_o[i]         = live_q[i].od;
        end
    end

    assign busy_o      = state_q != StIdle;
    assign done_o      = done_q;
    assign cfg_rdata_o = rdata;

endmodule

// File: tb/tb_gpio_pinmux_ctrl.sv
// Self-checking bench for gpio_pinmux_ctrl: directed scenarios plus random traffic against a
// transaction-level model of the commit sequence.
module tb_gpio_pinmux_ctrl;

    localparam int IOW     = 36;
    localparam int G       = 4;
    localparam int SEQ_LEN = G + 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                cfg_wr = 1'b0;
    logic                cfg_rd = 1'b0;
    logic                cfg_commit = 1'b0;
    logic [5:0]          cfg_addr = '0;
    logic [9:0]          cfg_wdata = '0;
    logic [9:0]          cfg_rdata;
    logic                busy, done, cfg_err;
    logic [IOW-1:0][7:0] portselnum;
    logic [IOW-1:0]      out_ena, od;
`ifdef GPIO_PINMUX_LIVE_READBACK_EN
    logic                cfg_rd_live = 1'b0;
`endif

    gpio_pinmux_ctrl #(
        .IOWidth      (IOW),
        .PortNumWidth (8),
        .AddrWidth    (6),
        .GuardCycles  (G)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg_wr_i      (cfg_wr),
        .cfg_rd_i      (cfg_rd),
`ifdef GPIO_PINMUX_LIVE_READBACK_EN
        .cfg_rd_live_i (cfg_rd_live),
`endif
        .cfg_addr_i    (cfg_addr),
        .cfg_wdata_i   (cfg_wdata),
        .cfg_rdata_o   (cfg_rdata),
        .commit_i      (cfg_commit),
        .busy_o        (busy),
        .done_o        (done),
        .cfg_err_o     (cfg_err),
        .portselnum_o  (portselnum),
        .out_ena_o     (out_ena),
        .od_o          (od)
    );

    always #5 clk = ~clk;

    // Reference model; entries packed as {od, oe, sel}.
    logic [9:0]     m_sh [IOW];
    logic [9:0]     m_snap [IOW];
    logic [7:0]     m_sel [IOW];
    logic [IOW-1:0] m_oe, m_od, m_chg;
    logic [9:0]     m_rdata;
    logic           m_err, m_pend, m_done;
    int             m_rem;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < IOW; i++) begin
            m_sh[i]   = {2'b00, 8'(i)};
            m_snap[i] = {2'b00, 8'(i)};
            m_sel[i]  = 8'(i);
        end
        m_oe = '0; m_od = '0; m_chg = '0;
        m_rdata = '0; m_err = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_rem = 0;
    endtask

    task automatic model_edge();
        logic [9:0] nsh [IOW];
        int k;
        for (int i = 0; i < IOW; i++) nsh[i] = m_sh[i];
        if (cfg_wr) begin
            if (int'(cfg_addr) < IOW && int'(cfg_wdata[7:0]) < IOW) nsh[int'(cfg_addr)] = cfg_wdata;
            else m_err = 1'b1;
        end
        if (cfg_rd) m_rdata = (int'(cfg_addr) < IOW) ? m_sh[int'(cfg_addr)] : 10'd0;
        m_done = 1'b0;
        if (m_rem == 0) begin
            if (cfg_commit || m_pend) begin
                m_pend = 1'b0;
                for (int i = 0; i < IOW; i++) begin
                    m_snap[i] = nsh[i];
                    m_chg[i]  = (nsh[i][7:0] != m_sel[i]) || (nsh[i][9] != m_od[i]);
                end
                m_rem = SEQ_LEN;
            end
        end else begin
            if (cfg_commit) m_pend = 1'b1;
            k = SEQ_LEN - m_rem + 1;
            if (k == 1) m_oe = m_oe & ~m_chg;
            if (k == G + 2) begin
                for (int i = 0; i < IOW; i++) begin
                    m_sel[i] = m_snap[i][7:0];
                    m_od[i]  = m_snap[i][9];
                end
            end
            if (k == SEQ_LEN) begin
                for (int i = 0; i < IOW; i++) m_oe[i] = m_snap[i][8];
                m_done = 1'b1;
            end
            m_rem--;
        end
        for (int i = 0; i < IOW; i++) m_sh[i] = nsh[i];
    endtask

    task automatic compare_all();
        logic [IOW-1:0][7:0] e_sel;
        for (int i = 0; i < IOW; i++) e_sel[i] = m_sel[i];
        check_eq("portselnum", portselnum, e_sel);
        check_eq("out_ena", out_ena, m_oe);
        check_eq("od", od, m_od);
        check_eq("busy", busy, m_rem != 0);
        check_eq("done", done, m_done);
        check_eq("cfg_err", cfg_err, m_err);
        check_eq("cfg_rdata", cfg_rdata, m_rdata);
    endtask

    // Inputs are stable at the edge; outputs are sampled 2 time units after it.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #2;
        compare_all();
    endtask

    task automatic write_pin(input int a, input logic [9:0] d);
        cfg_wr = 1'b1; cfg_addr = 6'(a); cfg_wdata = d;
        cycle();
        cfg_wr = 1'b0;
    endtask

    task automatic read_pin(input int a);
        cfg_rd = 1'b1; cfg_addr = 6'(a);
        cycle();
        cfg_rd = 1'b0;
    endtask

    initial begin
        int bcnt, ndone;
        logic got;

        model_reset();
        #1 rst_n = 1'b0;
        #10;
        compare_all();
        rst_n = 1'b1;
        cycle();
        check_eq("rst_sel5", portselnum[5], 8'd5);
        check_eq("rst_oe", out_ena, '0);
        read_pin(5);
        check_eq("rd_addr5", cfg_rdata, 10'h005);

        // Pin 2 driving, so it can be watched while pin 3 is reconfigured.
        write_pin(2, {2'b01, 8'd2});
        cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
        for (int n = 0; n < 8; n++) cycle();
        check_eq("pin2_on", out_ena[2], 1'b1);

        write_pin(3, {2'b01, 8'd7});
        cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
        bcnt = busy ? 1 : 0;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            if (busy) bcnt++;
            check_eq("pin2_held", out_ena[2], 1'b1);
            if (k == 6) begin
                check_eq("pin3_sel_apply", portselnum[3], 8'd7);
                check_eq("pin3_oe_low", out_ena[3], 1'b0);
            end
            if (k == 7) begin
                check_eq("pin3_oe_enable", out_ena[3], 1'b1);
                check_eq("done_at_e7", done, 1'b1);
            end
        end
        check_eq("busy_len", bcnt, SEQ_LEN);

        // Commit held through a sequence plus a write: exactly one follow-up sequence.
        cfg_commit = 1'b1; cycle();
        write_pin(4, {2'b01, 8'd9});
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            cycle();
            if (done) got = 1'b1;
        end
        check_eq("first_done_seen", got, 1'b1);
        cfg_commit = 1'b0;
        cycle();
        check_eq("pending_restart", busy, 1'b1);
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (done) ndone++;
        end
        check_eq("extra_seq_count", ndone, 1);
        check_eq("pin4_sel", portselnum[4], 8'd9);
        check_eq("pin4_oe", out_ena[4], 1'b1);

        // Dropped writes.
        write_pin(40, {2'b01, 8'd1});
        check_eq("err_addr", cfg_err, 1'b1);
        write_pin(6, {2'b01, 8'd36});
        read_pin(6);
        check_eq("shadow6_kept", cfg_rdata, 10'h006);
        cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
        for (int n = 0; n < 10; n++) cycle();
        check_eq("err_sticky", cfg_err, 1'b1);
        check_eq("pin6_sel", portselnum[6], 8'd6);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cfg_wr     = ($urandom_range(0, 99) < 50);
            cfg_rd     = ($urandom_range(0, 99) < 30);
            cfg_commit = ($urandom_range(0, 99) < 10);
            cfg_addr   = 6'($urandom_range(0, 44));
            cfg_wdata  = {1'($urandom), 1'($urandom), 8'($urandom_range(0, 40))};
            cycle();
        end
        cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_commit = 1'b0;
        for (int n = 0; n < 25; n++) cycle();

        // Reset while in the guard dwell.
        write_pin(3, {2'b11, 8'd20});
        cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
        cycle();
        cycle();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_sel3", portselnum[3], 8'd3);
        check_eq("rst_mid_oe", out_ena, '0);
        #3 rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (done) ndone++;
        end
        check_eq("no_done_after_rst", ndone, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
